// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the I/O-to-memory command responder.
package mem_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 64;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_CLEAR,
    S_DONE
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word store: synchronous write, registered read, one port of each.
module mem_array
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset so it maps onto RAM; only an explicit CLEAR zeroes it.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/memory_control.sv
// Responder FSM: accepts a handshaked command, runs it against mem_array, reports completion.
module memory_control
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memCmd,
  input  logic [ADDR_W-1:0] memAddrOut,
  input  logic [DATA_W-1:0] ioDataOut,
  input  logic              ioCmdDoneOut,
  output logic              memCmdDoneIn,
  output logic [DATA_W-1:0] memDataIn
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            r_state, w_next;
  cmd_e              r_cmd;
  logic [IDX_W-1:0]  r_idx, r_clr_idx;
  logic [DATA_W-1:0] r_wdata, r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic [IDX_W-1:0]  w_in_idx, w_rd_idx, w_waddr;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  logic              w_we, w_accept, w_busy_end, w_clr_end;
  logic              w_unused_addr;

  assign w_in_idx      = memAddrOut[IDX_W+1:2];
  assign w_unused_addr = ^{memAddrOut[ADDR_W-1:IDX_W+2], memAddrOut[1:0]};
  assign w_accept      = (r_state == S_IDLE) && ioCmdDoneOut && (cmd_e'(memCmd) != CMD_NOP);
  assign w_busy_end    = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_clr_end     = (r_state == S_CLEAR) && (r_clr_idx == IDX_W'(DEPTH - 1));
  // Pre-address the store at acceptance so read data is settled before the countdown ends.
  assign w_rd_idx      = (r_state == S_IDLE) ? w_in_idx : r_idx;
  assign memDataIn     = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next       = r_state;
    memCmdDoneIn = 1'b1;
    w_we         = 1'b0;
    w_waddr      = r_idx;
    w_wdata      = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (cmd_e'(memCmd) == CMD_CLEAR) ? S_CLEAR : S_BUSY;
      end
      S_BUSY: begin
        memCmdDoneIn = 1'b0;
        w_we         = w_busy_end && (r_cmd == CMD_WRITE);
        if (w_busy_end) w_next = S_DONE;
      end
      S_CLEAR: begin
        memCmdDoneIn = 1'b0;
        w_we         = 1'b1;
        w_waddr      = r_clr_idx;
        w_wdata      = '0;
        if (w_clr_end) w_next = S_DONE;
      end
      S_DONE: begin
        if (!ioCmdDoneOut) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd     <= CMD_NOP;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_clr_idx <= '0;
      r_data    <= '0;
    end else begin
      if (w_accept) begin
        r_cmd     <= cmd_e'(memCmd);
        r_idx     <= w_in_idx;
        r_wdata   <= ioDataOut;
        r_cnt     <= CNT_W'(LATENCY - 1);
        r_clr_idx <= '0;
      end
      if ((r_state == S_BUSY) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
      if (w_busy_end && (r_cmd == CMD_READ)) r_data <= w_rdata;
      if (w_clr_end) r_data <= '0;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata)
  );

endmodule
